// File: rtl/board_rst_seq_if.sv
`default_nettype none
// =============================================================================
// Module   : board_rst_seq_if
// Brief    : Board-side reset sources and staged reset outputs of board_rst_seq.
// Revision : 1.0
// =============================================================================
interface board_rst_seq_if;
    logic       BOARD_RST_SW;
    logic       SL_RST_N;
    logic       SYS_CLK_STABLE;
    logic       SYS_RST_N;
    logic       DUT_RST_N;
    logic [1:0] RST_CAUSE;
    logic [7:0] RST_COUNT;
    logic       LOCK_TIMEOUT;

    modport master (
        output BOARD_RST_SW, SL_RST_N, SYS_CLK_STABLE,
        input  SYS_RST_N, DUT_RST_N, RST_CAUSE, RST_COUNT, LOCK_TIMEOUT
    );

    modport slave (
        input  BOARD_RST_SW, SL_RST_N, SYS_CLK_STABLE,
        output SYS_RST_N, DUT_RST_N, RST_CAUSE, RST_COUNT, LOCK_TIMEOUT
    );
endinterface
`default_nettype wire

// File: rtl/board_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : board_rst_seq
// Brief    : Synchronizes/debounces board reset sources and releases the DUT
//            resets in two stages; optional lock-loss timeout via
//            RST_SEQ_LOCK_TIMEOUT_EN.
// Revision : 1.0
// =============================================================================
module board_rst_seq #(
    parameter int unsigned P_DEBOUNCE_CYC     = 80000,
    parameter int unsigned P_LOCK_HOLD_CYC    = 1024,
    parameter int unsigned P_STAGE_GAP_CYC    = 16,
    parameter int unsigned P_LOCK_TIMEOUT_CYC = 8000000,
    parameter int unsigned P_CNT_WIDTH        = 24
) (
    input  wire logic      SYS_CLK,
    input  wire logic      SYS_RST,
    board_rst_seq_if.slave bus
);

    localparam logic [P_CNT_WIDTH-1:0] c_db_last   = P_CNT_WIDTH'(P_DEBOUNCE_CYC - 1);
    localparam logic [P_CNT_WIDTH-1:0] c_hold_last = P_CNT_WIDTH'(P_LOCK_HOLD_CYC - 1);
    localparam logic [P_CNT_WIDTH-1:0] c_gap_last  = P_CNT_WIDTH'(P_STAGE_GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HOLD  = 2'd1,
        S_REL1  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    logic r_sw_meta,   r_sw_sync;
    logic r_sl_meta,   r_sl_sync;
    logic r_lock_meta, r_lock_sync;

    logic                   r_sw_db;
    logic [P_CNT_WIDTH-1:0] r_db_cnt;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [P_CNT_WIDTH-1:0] r_seq_cnt;
    logic                   r_sys_rst_n;
    logic                   r_dut_rst_n;
    logic [1:0]             r_cause;
    logic [7:0]             r_count;

    logic       w_req;
    logic [1:0] w_cause;

    // Synchronizers come out of reset in the "request active" state.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_sw_meta   <= 1'b1;
            r_sw_sync   <= 1'b1;
            r_sl_meta   <= 1'b0;
            r_sl_sync   <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_sw_meta   <= bus.BOARD_RST_SW;
            r_sw_sync   <= r_sw_meta;
            r_sl_meta   <= bus.SL_RST_N;
            r_sl_sync   <= r_sl_meta;
            r_lock_meta <= bus.SYS_CLK_STABLE;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_sw_db  <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_sw_sync != r_sw_db) begin
            if (r_db_cnt >= c_db_last) begin
                r_sw_db  <= r_sw_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_req = SYS_RST | r_sw_db | ~r_sl_sync | ~r_lock_sync;

    // Simultaneous sources: lock loss outranks switch, switch outranks FX3.
    always_comb begin
        if (!r_lock_sync) begin
            w_cause = 2'd1;
        end else if (r_sw_db) begin
            w_cause = 2'd2;
        end else begin
            w_cause = 2'd3;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_req) begin
            w_state_nxt = S_RESET;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_HOLD;
                S_HOLD:  if (r_seq_cnt >= c_hold_last) w_state_nxt = S_REL1;
                S_REL1:  if (r_seq_cnt >= c_gap_last)  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_RESET;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state     <= S_RESET;
            r_seq_cnt   <= '0;
            r_sys_rst_n <= 1'b0;
            r_dut_rst_n <= 1'b0;
            r_cause     <= 2'd0;
            r_count     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            // Any state change restarts the stage timer, so an aborted hold earns no credit.
            if ((w_state_nxt != r_state) || (r_state == S_RESET)) begin
                r_seq_cnt <= '0;
            end else if ((r_state == S_HOLD) || (r_state == S_REL1)) begin
                r_seq_cnt <= r_seq_cnt + 1'b1;
            end

            r_sys_rst_n <= (w_state_nxt == S_REL1) || (w_state_nxt == S_RUN);
            r_dut_rst_n <= (w_state_nxt == S_RUN);

            if (w_req && (r_state != S_RESET)) begin
                r_cause <= w_cause;
            end

            if (w_req && (r_state == S_RUN) && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.SYS_RST_N = r_sys_rst_n;
    assign bus.DUT_RST_N = r_dut_rst_n;
    assign bus.RST_CAUSE = r_cause;
    assign bus.RST_COUNT = r_count;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    localparam logic [P_CNT_WIDTH-1:0] c_lto_max  = P_CNT_WIDTH'(P_LOCK_TIMEOUT_CYC);
    localparam logic [P_CNT_WIDTH-1:0] c_lto_last = P_CNT_WIDTH'(P_LOCK_TIMEOUT_CYC - 1);

    logic [P_CNT_WIDTH-1:0] r_lto_cnt;
    logic                   r_lock_timeout;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || r_lock_sync) begin
            r_lto_cnt      <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            if (r_lto_cnt != c_lto_max) begin
                r_lto_cnt <= r_lto_cnt + 1'b1;
            end
            if (r_lto_cnt >= c_lto_last) begin
                r_lock_timeout <= 1'b1;
            end
        end
    end

    assign bus.LOCK_TIMEOUT = r_lock_timeout;
`else
    // Timeout logic absent; the parameter only keeps the output constant-folded to zero.
    assign bus.LOCK_TIMEOUT = 1'b0 & (P_LOCK_TIMEOUT_CYC == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_board_rst_seq
// Brief    : Directed + randomized bench for board_rst_seq with a run-length
//            reference model of the reset sequence.
// Revision : 1.0
// =============================================================================
module tb_board_rst_seq;

    localparam int DB   = 8;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TO   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    board_rst_seq_if bus ();

    board_rst_seq #(
        .P_DEBOUNCE_CYC     (DB),
        .P_LOCK_HOLD_CYC    (HOLD),
        .P_STAGE_GAP_CYC    (GAP),
        .P_LOCK_TIMEOUT_CYC (TO),
        .P_CNT_WIDTH        (24)
    ) u_dut (
        .SYS_CLK (clk),
        .SYS_RST (rst),
        .bus     (bus)
    );

    int unsigned vec   = 0;
    int unsigned fails = 0;

    // Reference model state: sync pipelines, debounce window, quiet-run length.
    logic       m_sw1 = 1'b1, m_sw2 = 1'b1;
    logic       m_sl1 = 1'b0, m_sl2 = 1'b0;
    logic       m_lk1 = 1'b0, m_lk2 = 1'b0;
    logic       m_db  = 1'b1;
    bit         hist[$];
    int         m_k    = 0;
    int         m_lrun = 0;
    logic [1:0] m_cause = 2'd0;
    logic [7:0] m_count = 8'd0;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vec++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic        req;
        logic        all_diff;
        logic        e_to;
        logic [12:0] exp;
        logic [12:0] obs;

        req = rst | m_db | ~m_sl2 | ~m_lk2;

        if (rst) begin
            m_cause = 2'd0;
            m_count = 8'd0;
        end else if (req && (m_k >= 1)) begin
            m_cause = !m_lk2 ? 2'd1 : (m_db ? 2'd2 : 2'd3);
            if ((m_k >= HOLD + GAP + 1) && (m_count != 8'hFF)) m_count = m_count + 8'd1;
        end
        m_k = req ? 0 : m_k + 1;

        if (rst) begin
            m_db = 1'b1;
            hist.delete();
        end else begin
            hist.push_back(m_sw2);
            if (hist.size() > DB) void'(hist.pop_front());
            all_diff = (hist.size() == DB);
            foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
        end

        m_lrun = (rst || m_lk2) ? 0 : m_lrun + 1;

        if (rst) begin
            m_sw1 = 1'b1; m_sw2 = 1'b1;
            m_sl1 = 1'b0; m_sl2 = 1'b0;
            m_lk1 = 1'b0; m_lk2 = 1'b0;
        end else begin
            m_sw2 = m_sw1; m_sw1 = bus.BOARD_RST_SW;
            m_sl2 = m_sl1; m_sl1 = bus.SL_RST_N;
            m_lk2 = m_lk1; m_lk1 = bus.SYS_CLK_STABLE;
        end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
        e_to = (m_lrun >= TO);
`else
        e_to = 1'b0;
`endif
        exp = {(m_k >= HOLD + 1), (m_k >= HOLD + GAP + 1), m_cause, m_count, e_to};

        @(posedge clk);
        #1;
        obs = {bus.SYS_RST_N, bus.DUT_RST_N, bus.RST_CAUSE, bus.RST_COUNT, bus.LOCK_TIMEOUT};
        chk(tag, obs, exp);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Compares only the listed fields against fixed scenario outcomes.
    task automatic chk_state(input string tag, input logic dut_n, input logic [1:0] cause,
                             input logic [7:0] count);
        chk(tag, {2'b00, bus.DUT_RST_N, bus.RST_CAUSE, bus.RST_COUNT},
                 {2'b00, dut_n, cause, count});
    endtask

    initial begin
        bus.BOARD_RST_SW   = 1'b0;
        bus.SL_RST_N       = 1'b1;
        bus.SYS_CLK_STABLE = 1'b1;

        // Power-up
        rst = 1'b1;
        run(5, "powerup_rst");
        rst = 1'b0;
        run(40, "powerup_release");
        chk_state("powerup_final", 1'b1, 2'd0, 8'd0);

        // FX3 reset pulse
        bus.SL_RST_N = 1'b0;
        run(1, "sl_pulse");
        bus.SL_RST_N = 1'b1;
        run(2, "sl_assert");
        chk({1'b0, bus.SYS_RST_N, bus.DUT_RST_N, 10'd0}, {1'b0, 2'b00, 10'd0}, 13'd0);
        run(40, "sl_release");
        chk_state("sl_final", 1'b1, 2'd3, 8'd1);

        // Switch bounce, then a solid press
        for (int i = 0; i < 10; i++) begin
            bus.BOARD_RST_SW = ~bus.BOARD_RST_SW;
            run(3, "sw_bounce");
        end
        chk_state("sw_no_reset", 1'b1, 2'd3, 8'd1);
        bus.BOARD_RST_SW = 1'b1;
        run(20, "sw_press");
        chk_state("sw_asserted", 1'b0, 2'd2, 8'd2);
        bus.BOARD_RST_SW = 1'b0;
        run(45, "sw_release");

        // Lock loss in RUN, then again during the hold
        bus.SYS_CLK_STABLE = 1'b0;
        run(5, "lock_drop");
        bus.SYS_CLK_STABLE = 1'b1;
        run(12, "lock_hold");
        bus.SYS_CLK_STABLE = 1'b0;
        run(1, "lock_mid_hold");
        bus.SYS_CLK_STABLE = 1'b1;
        run(40, "lock_restart");
        chk_state("lock_final", 1'b1, 2'd1, 8'd3);

        // Lock and FX3 together
        bus.SYS_CLK_STABLE = 1'b0;
        bus.SL_RST_N       = 1'b0;
        run(1, "dual_drop");
        bus.SYS_CLK_STABLE = 1'b1;
        bus.SL_RST_N       = 1'b1;
        run(40, "dual_release");
        chk_state("dual_final", 1'b1, 2'd1, 8'd4);

        // Long lock loss exercises the timeout flag
        bus.SYS_CLK_STABLE = 1'b0;
        run(40, "lock_long");
        bus.SYS_CLK_STABLE = 1'b1;
        run(40, "lock_long_release");
        chk_state("lock_long_final", 1'b1, 2'd1, 8'd5);

        // Randomized source activity
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 199);
            rst = (r == 0);
            if (r >= 1 && r < 5)   bus.SL_RST_N       = ~bus.SL_RST_N;
            else if (r >= 5 && r < 8)  bus.SYS_CLK_STABLE = ~bus.SYS_CLK_STABLE;
            else if (r >= 8 && r < 16) bus.BOARD_RST_SW   = ~bus.BOARD_RST_SW;
            else if (r >= 16 && r < 60) begin
                bus.SL_RST_N       = 1'b1;
                bus.SYS_CLK_STABLE = 1'b1;
                bus.BOARD_RST_SW   = 1'b0;
            end
            tick("random");
        end

        // Counter saturation
        rst                = 1'b1;
        bus.SL_RST_N       = 1'b1;
        bus.SYS_CLK_STABLE = 1'b1;
        bus.BOARD_RST_SW   = 1'b0;
        run(2, "sat_rst");
        rst = 1'b0;
        run(40, "sat_release");
        chk_state("sat_start", 1'b1, 2'd0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            bus.SL_RST_N = 1'b0;
            tick("sat_pulse");
            bus.SL_RST_N = 1'b1;
            run(30, "sat_release");
        end
        chk_state("sat_final", 1'b1, 2'd3, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_rst_seq.md
Name: board_rst_seq

Overview:
- Reset sequencer for the board top level. It sits between the clock manager/board pins and the DUT.
- Synchronizes and debounces the raw reset sources: board push-button, FX3 SL_RST_N and PLL lock.
- Releases the DUT resets in a fixed, staged order once all sources have been quiet for a programmable hold time.
- Records the cause of the last reset and counts in-service reset events for debug.

Parameters:
P_DEBOUNCE_CYC, 80000, consecutive stable cycles required before the debounced switch changes (1 ms at 80 MHz)
P_LOCK_HOLD_CYC, 1024, cycles with all requests clear before stage-1 release
P_STAGE_GAP_CYC, 16, cycles between SYS_RST_N release and DUT_RST_N release
P_LOCK_TIMEOUT_CYC, 8000000, lock-loss timeout, used only with the optional feature
P_CNT_WIDTH, 24, width of internal counters; must hold the largest *_CYC value

Ports:
SYS_CLK  input  1  system clock, single clock domain
SYS_RST  input  1  global power-on reset, synchronous, active-high
BOARD_RST_SW  input  1  raw push-button, asynchronous, active-high
SL_RST_N  input  1  FX3 reset, asynchronous, active-low
SYS_CLK_STABLE  input  1  PLL locked, asynchronous, active-high
SYS_RST_N  output  1  stage-1 reset to DUT infrastructure, active-low
DUT_RST_N  output  1  stage-2 reset to DUT core/bus, active-low
RST_CAUSE  output  2  cause of last reset: 0=SYS_RST, 1=lock loss, 2=switch, 3=SL_RST_N
RST_COUNT  output  8  saturating count of resets entered from S_RUN
LOCK_TIMEOUT  output  1  lock-loss timeout flag (optional feature)

Behaviour:
- One clock: SYS_CLK. Reset: SYS_RST, synchronous, active-high.
- Synchronizers:
  - BOARD_RST_SW, SL_RST_N and SYS_CLK_STABLE each pass through 2-flop synchronizers.
  - Synchronizer flops reset to the "request active" value: sw=1, sl_n=0, lock=0.
- Debounce:
  - sw_db takes the synchronized switch value only after that value differs from sw_db for P_DEBOUNCE_CYC consecutive cycles.
  - Any glitch back to the sw_db value restarts the count.
  - SYS_RST sets sw_db=1.
- Request: req = SYS_RST | sw_db | ~sl_sync | ~lock_sync.
- FSM states: S_RESET, S_HOLD, S_REL1, S_RUN. SYS_RST forces S_RESET.
  - Any state, req=1: next state S_RESET. This has priority over all other transitions.
  - S_RESET, req=0: go to S_HOLD and clear the counter.
  - S_HOLD: count cycles; after P_LOCK_HOLD_CYC cycles go to S_REL1 and clear the counter.
  - S_REL1: count cycles; after P_STAGE_GAP_CYC cycles go to S_RUN.
  - S_RUN: stay until req.
- Outputs are registered from the next state:
  - SYS_RST_N = 1 in S_REL1 and S_RUN.
  - DUT_RST_N = 1 in S_RUN only.
  - Both outputs reset to 0.
- Assertion latency: async source edge to both outputs low is at most 3 SYS_CLK cycles (2 sync + 1 register). For the switch, add P_DEBOUNCE_CYC.
- Release latency: from the first cycle with req=0:
  - SYS_RST_N rises after P_LOCK_HOLD_CYC+1 cycles.
  - DUT_RST_N rises P_STAGE_GAP_CYC cycles after SYS_RST_N.
- Reset mid-sequence: req during S_HOLD or S_REL1 returns to S_RESET and the hold restarts from zero. There is no partial credit.
- RST_CAUSE:
  - Loaded on every transition into S_RESET from a non-S_RESET state.
  - Priority for simultaneous sources: SYS_RST > lock > switch > SL_RST_N.
  - SYS_RST sets it to 0. Otherwise it is held.
- RST_COUNT:
  - Increments on each S_RUN-to-S_RESET transition and saturates at 255.
  - Cleared only by SYS_RST. An SL_RST_N or switch reset does not clear it.

Optional Feature:
- Macro: RST_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - A counter runs while lock_sync=0 and clears when lock_sync=1.
  - LOCK_TIMEOUT is set when the count reaches P_LOCK_TIMEOUT_CYC.
  - It stays set until lock_sync returns to 1, then clears the cycle after.
  - SYS_RST clears it.
- Not defined: LOCK_TIMEOUT is tied to 0, the counter is absent, and the port is kept.

Test Plan:
Bench parameters: P_DEBOUNCE_CYC=8, P_LOCK_HOLD_CYC=16, P_STAGE_GAP_CYC=4, P_LOCK_TIMEOUT_CYC=32.
1. Power-up: SYS_RST high 5 cycles, then low, with lock=1, SL_RST_N=1, switch=0 -> SYS_RST_N rises 17 cycles after the first req=0 cycle, DUT_RST_N 4 cycles later; RST_CAUSE=0, RST_COUNT=0.
2. In S_RUN, pulse SL_RST_N low 1 cycle -> both outputs low within 3 cycles; RST_CAUSE=3, RST_COUNT=1; full 16+4 release repeats.
3. Switch bounce: toggle every 3 cycles for 30 cycles, then hold high -> no reset during bounce; reset asserted 8+3 cycles after the stable high; RST_CAUSE=2.
4. Lock drop at cycle 10 of S_HOLD -> returns to S_RESET, RST_COUNT unchanged, hold restarts; SYS_RST_N rises 17 cycles after lock returns plus sync delay.
5. Lock and SL_RST_N drop on the same cycle in S_RUN -> RST_CAUSE=1; 256 repeated S_RUN resets leave RST_COUNT=255.
6. With RST_SEQ_LOCK_TIMEOUT_EN defined, lock low for 40 cycles -> LOCK_TIMEOUT=1 at count 32, clears 1 cycle after lock_sync=1; with the macro undefined, LOCK_TIMEOUT stays 0.
